// File: rtl/apb_slave_mem_pkg.sv
// Shared types and constants for the APB memory responder and its register file.
package apb_slave_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2
    } state_t;

    localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

    // Word-index width; at least one bit even for a two-word memory.
    function automatic int idx_width(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/apb_mem_regfile.sv
// DEPTH x WIDTH register array: async clear, synchronous write, registered read port
// whose output register can also be forced to zero (error responses).
module apb_mem_regfile
    import apb_slave_mem_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32,
    parameter int AW    = idx_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rd_en,
    input  logic             rd_clr,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [DEPTH-1:0][WIDTH-1:0] words;
    logic [WIDTH-1:0]            rdata_reg;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_word
            logic [WIDTH-1:0] word_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    word_reg <= '0;
                end else if (we && (waddr == AW'(gi))) begin
                    word_reg <= wdata;
                end
            end

            assign words[gi] = word_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_reg <= '0;
        end else if (rd_clr) begin
            rdata_reg <= '0;
        end else if (rd_en) begin
            rdata_reg <= words[raddr];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/apb_slave_mem_resp.sv
// APB slave responder backed by a small word-addressed memory, with programmable
// wait states, decode/alignment error responses and a saturating error counter.
module apb_slave_mem_resp
    import apb_slave_mem_pkg::*;
#(
    parameter int                     PADDR_WIDTH  = 32,
    parameter int                     PWDATA_WIDTH = 32,
    parameter int                     PRDATA_WIDTH = 32,
    parameter int                     MEM_DEPTH    = 16,
    parameter logic [PADDR_WIDTH-1:0] BASE_ADDR    = '0
) (
    input  logic                    pclock,
    input  logic                    preset,
    input  logic [PADDR_WIDTH-1:0]  paddr,
    input  logic                    prwd,
    input  logic [PWDATA_WIDTH-1:0] pwdata,
    input  logic                    psel,
    input  logic                    penable,
    input  logic [2:0]              wait_cfg,
    output logic [PRDATA_WIDTH-1:0] prdata,
    output logic                    pready,
    output logic                    pslverr,
    output logic [7:0]              err_count
);

    localparam int AW = idx_width(MEM_DEPTH);

    state_t                  state_reg, state_next;
    logic [2:0]              cnt_reg, cnt_next;
    logic [AW-1:0]           idx_reg, idx_next;
    logic                    write_reg, write_next;
    logic [PWDATA_WIDTH-1:0] wdata_reg, wdata_next;
    logic                    err_reg, err_next;
    logic                    pready_reg, pready_next;
    logic                    pslverr_reg, pslverr_next;
    logic [7:0]              err_count_reg, err_count_next;

    logic                    setup, access;
    logic [AW-1:0]           bus_idx;
    logic                    bus_err;
    logic [PADDR_WIDTH:0]    addr_ext, lo_ext, hi_ext;

    logic                    take_setup, raise, raise_err, raise_wr;
    logic [AW-1:0]           raise_idx;
    logic                    mem_we, rd_en, rd_clr;
    logic [AW-1:0]           rd_addr;

    assign setup  = psel && !penable;
    assign access = psel && penable;

    // Range check done one bit wider so the upper limit cannot wrap.
    assign addr_ext = {1'b0, paddr};
    assign lo_ext   = {1'b0, BASE_ADDR};
    assign hi_ext   = lo_ext + (PADDR_WIDTH + 1)'(4 * MEM_DEPTH);
    assign bus_err  = (paddr[1:0] != 2'b00) || (addr_ext < lo_ext) || (addr_ext >= hi_ext);
    assign bus_idx  = AW'((paddr - BASE_ADDR) >> 2);

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        idx_next       = idx_reg;
        write_next     = write_reg;
        wdata_next     = wdata_reg;
        err_next       = err_reg;
        pready_next    = 1'b0;
        pslverr_next   = 1'b0;
        err_count_next = err_count_reg;
        mem_we         = 1'b0;
        take_setup     = 1'b0;
        raise          = 1'b0;
        raise_err      = err_reg;
        raise_wr       = write_reg;
        raise_idx      = idx_reg;

        case (state_reg)
            IDLE: begin
                take_setup = setup;
            end
            WAIT: begin
                if (!psel) begin
                    state_next = IDLE;
                end else if (penable) begin
                    cnt_next = cnt_reg - 3'd1;
                    if (cnt_reg == 3'd1) begin
                        state_next = ACCESS;
                        raise      = 1'b1;
                    end
                end
            end
            ACCESS: begin
                if (access) begin
                    state_next = IDLE;
                    if (err_reg) begin
                        if (err_count_reg != ERR_CNT_MAX) begin
                            err_count_next = err_count_reg + 8'd1;
                        end
                    end else if (write_reg) begin
                        mem_we = 1'b1;
                    end
                end else if (setup) begin
                    take_setup = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        if (take_setup) begin
            idx_next   = bus_idx;
            write_next = prwd;
            wdata_next = pwdata;
            err_next   = bus_err;
            if (wait_cfg == 3'd0) begin
                state_next = ACCESS;
                raise      = 1'b1;
                raise_err  = bus_err;
                raise_wr   = prwd;
                raise_idx  = bus_idx;
            end else begin
                state_next = WAIT;
                cnt_next   = wait_cfg;
            end
        end

        if (raise) begin
            pready_next  = 1'b1;
            pslverr_next = raise_err;
        end
    end

    // Read data is captured on the edge that raises pready, forced to zero on errors.
    assign rd_clr  = raise && raise_err;
    assign rd_en   = raise && !raise_err && !raise_wr;
    assign rd_addr = raise_idx;

    always_ff @(posedge pclock or negedge preset) begin
        if (!preset) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            idx_reg       <= '0;
            write_reg     <= 1'b0;
            wdata_reg     <= '0;
            err_reg       <= 1'b0;
            pready_reg    <= 1'b0;
            pslverr_reg   <= 1'b0;
            err_count_reg <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            idx_reg       <= idx_next;
            write_reg     <= write_next;
            wdata_reg     <= wdata_next;
            err_reg       <= err_next;
            pready_reg    <= pready_next;
            pslverr_reg   <= pslverr_next;
            err_count_reg <= err_count_next;
        end
    end

    apb_mem_regfile #(
        .DEPTH (MEM_DEPTH),
        .WIDTH (PRDATA_WIDTH),
        .AW    (AW)
    ) u_regfile (
        .clk    (pclock),
        .rst_n  (preset),
        .we     (mem_we),
        .waddr  (idx_reg),
        .wdata  (wdata_reg),
        .rd_en  (rd_en),
        .rd_clr (rd_clr),
        .raddr  (rd_addr),
        .rdata  (prdata)
    );

    assign pready    = pready_reg;
    assign pslverr   = pslverr_reg;
    assign err_count = err_count_reg;

endmodule

// File: tb/tb_apb_slave_mem_resp.sv
// Directed bench for apb_slave_mem_resp: scoreboard queue filled by the driver,
// drained by a monitor at every observed completion.
module tb_apb_slave_mem_resp;

    logic        pclock = 1'b0;
    logic        preset;
    logic [31:0] paddr;
    logic        prwd;
    logic [31:0] pwdata;
    logic        psel;
    logic        penable;
    logic [2:0]  wait_cfg;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic [7:0]  err_count;

    typedef struct {
        logic [31:0] addr;
        logic        chk_data;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    apb_slave_mem_resp dut (
        .pclock    (pclock),
        .preset    (preset),
        .paddr     (paddr),
        .prwd      (prwd),
        .pwdata    (pwdata),
        .psel      (psel),
        .penable   (penable),
        .wait_cfg  (wait_cfg),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr),
        .err_count (err_count)
    );

    always #5 pclock = ~pclock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every completion must match the oldest outstanding expectation.
    always @(negedge pclock) begin
        if (preset && psel && penable && pready) begin
            if (sb.size() == 0) begin
                check("unexpected_completion", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                $display("[TB] xfer addr=%h prdata=%h pslverr=%b", mon_e.addr, prdata, pslverr);
                check("pslverr", {31'd0, pslverr}, {31'd0, mon_e.err});
                if (mon_e.chk_data) check("prdata", prdata, mon_e.data);
            end
        end
    end

    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [2:0] wc, input logic [31:0] exp_rd, input logic exp_err,
                        input int exp_waits);
        exp_t e;
        int   waits;
        logic got;
        e.addr     = addr;
        e.chk_data = !wr || exp_err;
        e.data     = exp_err ? 32'd0 : exp_rd;
        e.err      = exp_err;
        @(posedge pclock); #1;
        psel = 1'b1; penable = 1'b0; paddr = addr; prwd = wr; pwdata = wd; wait_cfg = wc;
        sb.push_back(e);
        @(posedge pclock); #1;
        penable = 1'b1;
        waits = 0;
        got   = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge pclock);
            if (pready) begin
                got = 1'b1;
                break;
            end
            waits++;
        end
        check("pready_seen", {31'd0, got}, 32'd1);
        check("wait_states", waits, exp_waits);
        @(posedge pclock); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        preset = 1'b0; psel = 1'b0; penable = 1'b0; paddr = '0; prwd = 1'b0;
        pwdata = '0; wait_cfg = '0;
        @(negedge pclock);
        check("rst_prdata", prdata, 32'd0);
        check("rst_pready", {31'd0, pready}, 32'd0);
        check("rst_pslverr", {31'd0, pslverr}, 32'd0);
        check("rst_err_count", {24'd0, err_count}, 32'd0);
        @(posedge pclock); #1;
        preset = 1'b1;

        // zero-wait write and readback
        xfer(1'b1, 32'h4, 32'hDEADBEEF, 3'd0, 32'h0, 1'b0, 0);
        xfer(1'b0, 32'h4, 32'h0, 3'd0, 32'hDEADBEEF, 1'b0, 0);
        // three wait states
        xfer(1'b0, 32'h0, 32'h0, 3'd3, 32'h0, 1'b0, 3);

        // misaligned and out-of-range writes
        xfer(1'b1, 32'h2, 32'hAAAA5555, 3'd0, 32'h0, 1'b1, 0);
        xfer(1'b1, 32'h40, 32'h55AA55AA, 3'd1, 32'h0, 1'b1, 1);
        check("err_count_two", {24'd0, err_count}, 32'd2);
        xfer(1'b0, 32'h0, 32'h0, 3'd0, 32'h0, 1'b0, 0);

        // abort in WAIT after two penable cycles
        @(posedge pclock); #1;
        psel = 1'b1; penable = 1'b0; paddr = 32'h8; prwd = 1'b1; pwdata = 32'h1234; wait_cfg = 3'd5;
        @(posedge pclock); #1;
        penable = 1'b1;
        repeat (2) begin
            @(negedge pclock);
            check("abort_pready_wait", {31'd0, pready}, 32'd0);
        end
        @(posedge pclock); #1;
        psel = 1'b0; penable = 1'b0;
        repeat (3) begin
            @(negedge pclock);
            check("abort_pready_after", {31'd0, pready}, 32'd0);
        end
        xfer(1'b0, 32'h8, 32'h0, 3'd0, 32'h0, 1'b0, 0);
        check("abort_err_count", {24'd0, err_count}, 32'd2);

        // reset asserted mid-write while waiting
        xfer(1'b0, 32'h4, 32'h0, 3'd0, 32'hDEADBEEF, 1'b0, 0);
        @(posedge pclock); #1;
        psel = 1'b1; penable = 1'b0; paddr = 32'hC; prwd = 1'b1; pwdata = 32'h5555; wait_cfg = 3'd4;
        @(posedge pclock); #1;
        penable = 1'b1;
        @(negedge pclock);
        check("pre_reset_pready", {31'd0, pready}, 32'd0);
        #1 preset = 1'b0;
        #1;
        check("mid_rst_prdata", prdata, 32'd0);
        check("mid_rst_pready", {31'd0, pready}, 32'd0);
        check("mid_rst_pslverr", {31'd0, pslverr}, 32'd0);
        check("mid_rst_err_count", {24'd0, err_count}, 32'd0);
        psel = 1'b0; penable = 1'b0;
        @(posedge pclock); #1;
        preset = 1'b1;

        // penable without setup is ignored
        psel = 1'b1; penable = 1'b1; paddr = 32'h4; prwd = 1'b0; wait_cfg = 3'd0;
        repeat (2) begin
            @(negedge pclock);
            check("no_setup_pready", {31'd0, pready}, 32'd0);
        end
        @(posedge pclock); #1;
        psel = 1'b0; penable = 1'b0;

        xfer(1'b0, 32'h4, 32'h0, 3'd2, 32'h0, 1'b0, 2);
        xfer(1'b0, 32'hC, 32'h0, 3'd0, 32'h0, 1'b0, 0);

        // error counter saturation
        for (int k = 1; k <= 260; k++) begin
            xfer(1'b0, 32'h1, 32'h0, 3'd0, 32'h0, 1'b1, 0);
            check("err_count_sat", {24'd0, err_count}, (k > 255) ? 32'd255 : k);
        end

        @(posedge pclock);
        check("scoreboard_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
